// File: rtl/reg_file_onehot_if.sv
// Bus bundle for reg_file_onehot.
// master: write controls (we, wr_sel, wd), link write (bl_en, link_data),
//         read addresses (ra1..ra3), pc_plus8, clr_err; receives rd1..rd3, sel_err.
// slave : the register file side of the same signals.
interface reg_file_onehot_if #(
    parameter int WIDTH = 32
);
    logic             we;
    logic [15:0]      wr_sel;
    logic [WIDTH-1:0] wd;
    logic             bl_en;
    logic [WIDTH-1:0] link_data;
    logic [3:0]       ra1, ra2, ra3;
    logic [WIDTH-1:0] pc_plus8;
    logic             clr_err;
    logic [WIDTH-1:0] rd1, rd2, rd3;
    logic             sel_err;

    modport master (
        output we, wr_sel, wd, bl_en, link_data, ra1, ra2, ra3, pc_plus8, clr_err,
        input  rd1, rd2, rd3, sel_err
    );

    modport slave (
        input  we, wr_sel, wd, bl_en, link_data, ra1, ra2, ra3, pc_plus8, clr_err,
        output rd1, rd2, rd3, sel_err
    );
endinterface

// File: rtl/reg_file_onehot.sv
// Architectural register file R0-R14 with R15 reads returning pc_plus8.
// Write select is the one-hot output of the write-address decoder; malformed
// selects (zero or several bits) are dropped and latch a sticky sel_err.
// Ports: clk, reset (async, active-high), bus (reg_file_onehot_if.slave).

// One storage register.
module reg_cell #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk or posedge reset) begin
        if (reset)   q <= '0;
        else if (en) q <= d;
    end
endmodule

module reg_file_onehot #(
    parameter int WIDTH = 32
) (
    input logic               clk,
    input logic               reset,
    reg_file_onehot_if.slave  bus
);
    logic                   onehot_ok;
    logic                   wr_ok;
    logic [14:0]            en;
    logic [14:0][WIDTH-1:0] d;
    logic [14:0][WIDTH-1:0] regs;
    logic [15:0][WIDTH-1:0] view;
    logic                   sel_err_q;

    assign onehot_ok = ($countones(bus.wr_sel) == 1);
    assign wr_ok     = bus.we & onehot_ok;

    // wr_sel[15] has no register behind it, so a legal R15 write simply
    // falls away. R14 also takes the link write, which beats a normal write.
    always_comb begin
        en = '0;
        d  = '0;
        for (int n = 0; n < 14; n++) begin
            en[n] = wr_ok & bus.wr_sel[n];
            d[n]  = bus.wd;
        end
        en[14] = bus.bl_en | (wr_ok & bus.wr_sel[14]);
        d[14]  = bus.bl_en ? bus.link_data : bus.wd;
    end

    for (genvar g = 0; g < 15; g++) begin : g_reg
        reg_cell #(.WIDTH(WIDTH)) u_reg (
            .clk   (clk),
            .reset (reset),
            .en    (en[g]),
            .d     (d[g]),
            .q     (regs[g])
        );
    end

    // Slot 15 of the read view is the PC, so every 4-bit address is in range.
    assign view    = {bus.pc_plus8, regs};
    assign bus.rd1 = view[bus.ra1];
    assign bus.rd2 = view[bus.ra2];
    assign bus.rd3 = view[bus.ra3];

    // Setting wins over clearing in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                      sel_err_q <= 1'b0;
        else if (bus.we && !onehot_ok)  sel_err_q <= 1'b1;
        else if (bus.clr_err)           sel_err_q <= 1'b0;
    end

    assign bus.sel_err = sel_err_q;
endmodule

// File: tb/tb_reg_file_onehot.sv
module tb_reg_file_onehot;
    logic clk = 1'b1;
    logic reset;

    always #5 clk = ~clk;

    reg_file_onehot_if #(.WIDTH(32)) bus ();

    reg_file_onehot #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] rd1, rd2, rd3;
        logic        err;
        int          tag;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_r [15];
    logic        m_err;
    int          n_chk = 0;
    int          n_fail = 0;
    int          tag = 0;

    // Reference read: R15 is the PC, everything else is the stored value.
    function automatic logic [31:0] mread(input logic [3:0] a);
        if (a == 4'd15) return bus.pc_plus8;
        return m_r[int'(a)];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_r[i] = '0;
        m_err = 1'b0;
    endtask

    // What one rising edge does to the architectural state.
    task automatic model_edge();
        int cnt;
        cnt = $countones(bus.wr_sel);
        if (bus.we && cnt == 1) begin
            for (int i = 0; i < 15; i++)
                if (bus.wr_sel[i]) m_r[i] = bus.wd;
        end
        if (bus.we && cnt != 1) m_err = 1'b1;
        else if (bus.clr_err)   m_err = 1'b0;
        if (bus.bl_en) m_r[14] = bus.link_data;
    endtask

    // Push the expectation for the current inputs, then take one edge.
    task automatic step();
        exp_t e;
        e.rd1 = mread(bus.ra1);
        e.rd2 = mread(bus.ra2);
        e.rd3 = mread(bus.ra3);
        e.err = m_err;
        e.tag = tag;
        sb.push_back(e);
        tag++;
        @(posedge clk);
        if (!reset) model_edge();
        #1;
    endtask

    task automatic drive(input logic we, input logic [15:0] sel, input logic [31:0] wd,
                         input logic bl, input logic [31:0] ld, input logic clr);
        bus.we = we; bus.wr_sel = sel; bus.wd = wd;
        bus.bl_en = bl; bus.link_data = ld; bus.clr_err = clr;
    endtask

    task automatic rd(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] a3);
        bus.ra1 = a1; bus.ra2 = a2; bus.ra3 = a3;
    endtask

    task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %h expected %h", nm, t, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so each cycle they are sampled
    // mid-cycle on the falling edge against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("rd1", e.tag, bus.rd1, e.rd1);
                chk("rd2", e.tag, bus.rd2, e.rd2);
                chk("rd3", e.tag, bus.rd3, e.rd3);
                chk("sel_err", e.tag, {31'd0, bus.sel_err}, {31'd0, e.err});
            end
        end
    end

    initial begin
        reset = 1'b1;
        model_reset();
        drive(0, 16'h0, 32'h0, 0, 32'h0, 0);
        bus.pc_plus8 = 32'h0000_0108;
        rd(4'd0, 4'd14, 4'd15);
        #1;
        // Reset state, held and after release.
        step();
        reset = 1'b0;
        step();

        // Write every register, then read them back.
        for (int n = 0; n < 15; n++) begin
            drive(1, 16'(1 << n), 32'hA5A5_0000 + n, 0, 32'h0, 0);
            step();
        end
        drive(0, 16'h0, 32'h0, 0, 32'h0, 0);
        for (int n = 0; n < 15; n++) begin
            rd(4'(n), 4'((n + 7) % 15), 4'd15);
            step();
        end

        // R15 write stores nothing and is not an error.
        drive(1, 16'h8000, 32'hDEAD_BEEF, 0, 32'h0, 0);
        rd(4'd15, 4'd0, 4'd14);
        step();
        drive(0, 16'h0, 32'h0, 0, 32'h0, 0);
        step();

        // Same-cycle read returns old value, new value one edge later.
        drive(1, 16'h0008, 32'h11, 0, 32'h0, 0);
        step();
        rd(4'd3, 4'd0, 4'd2);
        drive(1, 16'h0008, 32'h22, 0, 32'h0, 0);
        step();
        drive(0, 16'h0, 32'h0, 0, 32'h0, 0);
        step();

        // Illegal selects and sel_err priority.
        drive(1, 16'h0005, 32'hFFFF_FFFF, 0, 32'h0, 0);
        step();
        drive(0, 16'h0, 32'h0, 0, 32'h0, 1);
        step();
        drive(1, 16'h0000, 32'h1, 0, 32'h0, 0);
        step();
        drive(1, 16'h0003, 32'h2, 0, 32'h0, 1);
        step();
        drive(0, 16'h0003, 32'h3, 0, 32'h0, 1);
        step();
        drive(0, 16'h0, 32'h0, 0, 32'h0, 0);
        rd(4'd0, 4'd1, 4'd2);
        step();

        // Link collision, then link in parallel with another write.
        rd(4'd14, 4'd1, 4'd15);
        drive(1, 16'h4000, 32'h1234, 1, 32'h0000_0204, 0);
        step();
        drive(1, 16'h0002, 32'h77, 1, 32'h300, 0);
        step();
        // Link during an illegal write still lands.
        drive(1, 16'h0006, 32'h5A5A, 1, 32'h404, 0);
        step();
        drive(0, 16'h0, 32'h0, 0, 32'h0, 1);
        step();

        // Async reset between edges with a write pending.
        drive(1, 16'h0020, 32'h55, 0, 32'h0, 0);
        rd(4'd5, 4'd14, 4'd15);
        step();
        drive(1, 16'h0020, 32'h99, 0, 32'h0, 0);
        #1;
        reset = 1'b1;
        model_reset();
        step();
        reset = 1'b0;
        step();
        drive(0, 16'h0, 32'h0, 0, 32'h0, 0);
        step();

        // Randomized traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] sel;
            if ($urandom_range(0, 3) == 0) sel = 16'($urandom);
            else                           sel = 16'(1 << $urandom_range(0, 15));
            drive(1'($urandom_range(0, 1)), sel, $urandom,
                  $urandom_range(0, 7) == 0, $urandom, $urandom_range(0, 7) == 0);
            rd(4'($urandom), 4'($urandom), 4'($urandom));
            bus.pc_plus8 = $urandom;
            step();
        end

        drive(0, 16'h0, 32'h0, 0, 32'h0, 0);
        repeat (2) @(negedge clk);
        n_chk++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
